// File: rtl/fir_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fir_mac_sequencer
// Purpose  : Control sequencer for the time-multiplexed FIR MAC datapath:
//            sample write, tap sweep, pipeline drain, reduce, output handshake.
// Revision : 1.0 - initial release
// ============================================================================
module fir_mac_sequencer #(
    parameter int DATA_WIDTH    = 24,
    parameter int FIR_DEPTH     = 2048,
    parameter int NUM_PIPELINES = 32,
    parameter int PIPE_LATENCY  = 4
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst,
    input  logic                                  i_en,
    input  logic                                  i_sample_valid,
    output logic                                  o_sample_ready,
    output logic                                  o_wr_en,
    output logic [$clog2(FIR_DEPTH)-1:0]          o_wr_addr,
    output logic [$clog2(FIR_DEPTH)-1:0]          o_newest_ptr,
    output logic                                  o_rd_en,
    output logic [((FIR_DEPTH/NUM_PIPELINES) > 1 ?
                   $clog2(FIR_DEPTH/NUM_PIPELINES) : 1)-1:0] o_tap_idx,
    output logic                                  o_acc_en,
    output logic                                  o_acc_first,
    output logic                                  o_reduce_start,
    output logic                                  o_result_valid,
    input  logic                                  i_out_ready,
    output logic                                  o_busy
);

    localparam int TAPS    = FIR_DEPTH / NUM_PIPELINES;
    localparam int AW      = $clog2(FIR_DEPTH);
    localparam int TW      = (TAPS > 1) ? $clog2(TAPS) : 1;
    // A single lane still needs one REDUCE cycle to carry the start pulse.
    localparam int RED_CYC = (NUM_PIPELINES > 1) ? $clog2(NUM_PIPELINES) : 1;
    localparam int CNT_MAX = (PIPE_LATENCY > RED_CYC) ? PIPE_LATENCY : RED_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [TW-1:0] TAP_LAST   = TW'(TAPS - 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(PIPE_LATENCY - 1);
    localparam logic [CW-1:0] RED_LAST   = CW'(RED_CYC - 1);

    generate
        if (DATA_WIDTH < 1 || PIPE_LATENCY < 1 || NUM_PIPELINES < 1 ||
            FIR_DEPTH != (1 << AW) ||
            (NUM_PIPELINES & (NUM_PIPELINES - 1)) != 0 ||
            TAPS * NUM_PIPELINES != FIR_DEPTH) begin : g_param_check
            $error("fir_mac_sequencer: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_MAC    = 3'd1,
        S_DRAIN  = 3'd2,
        S_REDUCE = 3'd3,
        S_OUTPUT = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [AW-1:0]           head_q, head_d;
    logic [AW-1:0]           newest_q, newest_d;
    logic [TW-1:0]           tap_q, tap_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [PIPE_LATENCY-1:0] acc_dly_q, acc_dly_d;
    logic [PIPE_LATENCY-1:0] first_dly_q, first_dly_d;
    logic                    sample_take;

    assign sample_take = (state_q == S_IDLE) && i_en && !i_rst && i_sample_valid;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            head_q      <= '0;
            newest_q    <= '0;
            tap_q       <= '0;
            cnt_q       <= '0;
            acc_dly_q   <= '0;
            first_dly_q <= '0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            newest_q    <= newest_d;
            tap_q       <= tap_d;
            cnt_q       <= cnt_d;
            acc_dly_q   <= acc_dly_d;
            first_dly_q <= first_dly_d;
        end
    end

    // Everything holds while i_en is low, so a stall resumes exactly in place.
    always_comb begin
        state_d  = state_q;
        head_d   = head_q;
        newest_d = newest_q;
        tap_d    = tap_q;
        cnt_d    = cnt_q;
        if (i_en) begin
            case (state_q)
                S_IDLE: begin
                    if (sample_take) begin
                        newest_d = head_q;
                        head_d   = head_q + AW'(1);
                        tap_d    = '0;
                        state_d  = S_MAC;
                    end
                end
                S_MAC: begin
                    if (tap_q == TAP_LAST) begin
                        tap_d   = '0;
                        cnt_d   = '0;
                        state_d = S_DRAIN;
                    end else begin
                        tap_d = tap_q + TW'(1);
                    end
                end
                S_DRAIN: begin
                    if (cnt_q == DRAIN_LAST) begin
                        cnt_d   = '0;
                        state_d = S_REDUCE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_REDUCE: begin
                    if (cnt_q == RED_LAST) begin
                        cnt_d   = '0;
                        state_d = S_OUTPUT;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_OUTPUT: begin
                    if (i_out_ready) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        acc_dly_d   = acc_dly_q;
        first_dly_d = first_dly_q;
        if (i_en) begin
            acc_dly_d[0]   = (state_q == S_MAC);
            first_dly_d[0] = (state_q == S_MAC) && (tap_q == '0);
            for (int i = 1; i < PIPE_LATENCY; i++) begin
                acc_dly_d[i]   = acc_dly_q[i-1];
                first_dly_d[i] = first_dly_q[i-1];
            end
        end
    end

    assign o_sample_ready = (state_q == S_IDLE) && i_en && !i_rst;
    assign o_wr_en        = sample_take;
    assign o_wr_addr      = head_q;
    assign o_newest_ptr   = newest_q;
    assign o_rd_en        = (state_q == S_MAC) && i_en;
    assign o_tap_idx      = tap_q;
    assign o_acc_en       = acc_dly_q[PIPE_LATENCY-1] && i_en;
    assign o_acc_first    = first_dly_q[PIPE_LATENCY-1] && i_en;
    // REDUCE is always entered with the counter cleared, so count 0 marks entry.
    assign o_reduce_start = (state_q == S_REDUCE) && (cnt_q == '0) && i_en;
    assign o_result_valid = (state_q == S_OUTPUT);
    assign o_busy         = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fir_mac_sequencer.sv
`default_nettype none
// Bench for fir_mac_sequencer: directed and random stimulus against a timeline
// model counted in enabled cycles, with queue-based expected/observed checking.
module tb_fir_mac_sequencer;

    localparam int DW       = 24;
    localparam int DEPTH    = 128;
    localparam int LANES    = 16;
    localparam int PL       = 3;
    localparam int T        = DEPTH / LANES;
    localparam int R        = $clog2(LANES);
    localparam int AW       = $clog2(DEPTH);
    localparam int TW       = $clog2(T);
    localparam int VALID_AT = T + PL + R + 1;
    localparam int PERIOD   = T + PL + R + 2;

    logic          clk, rst, en, sv, ready;
    logic          o_sample_ready, o_wr_en, o_rd_en, o_acc_en, o_acc_first;
    logic          o_reduce_start, o_result_valid, o_busy;
    logic [AW-1:0] o_wr_addr, o_newest_ptr;
    logic [TW-1:0] o_tap_idx;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    fir_mac_sequencer #(
        .DATA_WIDTH   (DW),
        .FIR_DEPTH    (DEPTH),
        .NUM_PIPELINES(LANES),
        .PIPE_LATENCY (PL)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_en          (en),
        .i_sample_valid(sv),
        .o_sample_ready(o_sample_ready),
        .o_wr_en       (o_wr_en),
        .o_wr_addr     (o_wr_addr),
        .o_newest_ptr  (o_newest_ptr),
        .o_rd_en       (o_rd_en),
        .o_tap_idx     (o_tap_idx),
        .o_acc_en      (o_acc_en),
        .o_acc_first   (o_acc_first),
        .o_reduce_start(o_reduce_start),
        .o_result_valid(o_result_valid),
        .i_out_ready   (ready),
        .o_busy        (o_busy)
    );

    int errors;
    int checks;
    int act;   // enabled clock edges since reset
    int cyc;   // all clock edges

    always @(posedge clk or posedge rst) begin
        if (rst) act <= 0;
        else if (en) act <= act + 1;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: unexpected DUT event, no expectation queued (t=%0t)", name, $time);
    endtask

    typedef struct packed {
        logic          busy, sready, wr_en, rd_en, acc_en, acc_first, reduce, valid;
        logic [AW-1:0] wr_addr;
        logic [AW-1:0] newest;
        logic          tap_care;
        logic [TW-1:0] tap;
    } cyc_t;

    cyc_t          exp_cyc_q[$];
    logic [AW-1:0] exp_wr_q[$];
    int            exp_res_q[$];

    // Reference model: one job at a time, every event placed at a fixed
    // offset d (in enabled cycles) from the accept cycle.
    bit m_busy;
    int m_a0, m_head, m_newest;

    always @(negedge clk) begin
        cyc_t e;
        int   d;
        e = '0;
        if (rst) begin
            m_busy   = 1'b0;
            m_head   = 0;
            m_newest = 0;
            exp_wr_q.delete();
            exp_res_q.delete();
        end else begin
            d           = act - m_a0;
            e.busy      = m_busy;
            e.sready    = !m_busy && en;
            e.wr_en     = !m_busy && en && sv;
            e.wr_addr   = AW'(m_head);
            e.newest    = AW'(m_newest);
            e.rd_en     = en && m_busy && d >= 1 && d <= T;
            e.acc_en    = en && m_busy && d >= 1 + PL && d <= T + PL;
            e.acc_first = en && m_busy && d == 1 + PL;
            e.reduce    = en && m_busy && d == T + PL + 1;
            e.valid     = m_busy && d >= VALID_AT;
            if (m_busy && d >= 1 && d <= T) begin
                e.tap_care = 1'b1;
                e.tap      = TW'(d - 1);
            end
            if (en) begin
                if (!m_busy && sv) begin
                    exp_wr_q.push_back(AW'(m_head));
                    exp_res_q.push_back(act + VALID_AT);
                    m_busy   = 1'b1;
                    m_a0     = act;
                    m_newest = m_head;
                    m_head   = (m_head + 1) % DEPTH;
                end else if (m_busy && d >= VALID_AT && ready) begin
                    m_busy = 1'b0;
                end
            end
        end
        exp_cyc_q.push_back(e);
    end

    bit prev_valid;

    always @(negedge clk) begin
        cyc_t          e;
        logic [7:0]    got_f, exp_f;
        logic [AW-1:0] wa;
        int            rt;
        #1;
        if (exp_cyc_q.size() == 0) begin
            fail_now("cycle_expectation");
        end else begin
            e     = exp_cyc_q.pop_front();
            got_f = {o_busy, o_sample_ready, o_wr_en, o_rd_en,
                     o_acc_en, o_acc_first, o_reduce_start, o_result_valid};
            exp_f = {e.busy, e.sready, e.wr_en, e.rd_en,
                     e.acc_en, e.acc_first, e.reduce, e.valid};
            chk("strobes", 64'(got_f), 64'(exp_f));
            chk("wr_addr", 64'(o_wr_addr), 64'(e.wr_addr));
            chk("newest_ptr", 64'(o_newest_ptr), 64'(e.newest));
            if (e.tap_care) chk("tap_idx", 64'(o_tap_idx), 64'(e.tap));
        end
        if (o_wr_en) begin
            if (exp_wr_q.size() == 0) begin
                fail_now("sample_write");
            end else begin
                wa = exp_wr_q.pop_front();
                chk("write_txn_addr", 64'(o_wr_addr), 64'(wa));
            end
        end
        if (o_result_valid && !prev_valid) begin
            if (exp_res_q.size() == 0) begin
                fail_now("result_valid");
            end else begin
                rt = exp_res_q.pop_front();
                chk("result_time", 64'(act), 64'(rt));
            end
        end
        prev_valid = o_result_valid && !rst;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int got;
        rst = 1'b1; en = 1'b1; sv = 1'b0; ready = 1'b0;
        repeat (3) step();
        rst = 1'b0;

        // single sample from reset
        repeat (2) step();
        sv = 1'b1;
        step();
        sv = 1'b0;
        ready = 1'b1;
        repeat (PERIOD + 5) step();

        // back-to-back samples through a full pointer wrap
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        sv = 1'b1; ready = 1'b1;
        repeat ((DEPTH + 1) * PERIOD) step();
        sv = 1'b0;
        repeat (PERIOD + 2) step();

        // serializer back-pressure with a waiting sample
        ready = 1'b0; sv = 1'b1;
        repeat (VALID_AT + 100) step();
        ready = 1'b1;
        repeat (3) step();
        sv = 1'b0;
        repeat (PERIOD + 2) step();

        // 10-cycle stall in the middle of the tap sweep
        c0 = cyc;
        sv = 1'b1;
        step();
        sv = 1'b0;
        repeat (5) step();
        en = 1'b0;
        #1;
        chk("stall_tap_held", 64'(o_tap_idx), 64'(5));
        chk("stall_rd_en", 64'(o_rd_en), 64'(0));
        repeat (10) step();
        en = 1'b1;
        got = -1;
        for (int i = 0; i < 60; i++) begin
            if (o_result_valid) begin
                got = cyc - c0;
                break;
            end
            step();
        end
        chk("stall_valid_latency", 64'(got), 64'(VALID_AT + 10));
        repeat (PERIOD + 2) step();

        // asynchronous reset during DRAIN
        sv = 1'b1;
        step();
        sv = 1'b0;
        repeat (T + 1) step();
        #2;
        rst = 1'b1;
        sv  = 1'b1;
        #1;
        chk("rst_async_outputs",
            64'({o_busy, o_sample_ready, o_wr_en, o_rd_en, o_acc_en,
                 o_acc_first, o_reduce_start, o_result_valid}), 64'(0));
        chk("rst_async_ptrs", 64'({o_wr_addr, o_newest_ptr}), 64'(0));
        step();
        sv = 1'b0;
        step();
        rst = 1'b0;
        step();
        sv = 1'b1;
        #1;
        chk("post_rst_write", 64'({o_wr_en, o_wr_addr}), 64'({1'b1, {AW{1'b0}}}));
        step();
        sv = 1'b0;
        repeat (PERIOD + 2) step();

        // randomized enable / valid / ready traffic
        for (int i = 0; i < 3000; i++) begin
            en    = ($urandom_range(0, 9) != 0);
            sv    = $urandom_range(0, 1) != 0;
            ready = ($urandom_range(0, 2) != 0);
            step();
        end

        en = 1'b1; sv = 1'b0; ready = 1'b1;
        repeat (PERIOD + 5) step();
        chk("pending_writes", 64'(exp_wr_q.size()), 64'(0));
        chk("pending_results", 64'(exp_res_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
